// File: rtl/secded_lock_pipe_pkg.sv
// Shared definitions for the SEC-DED decoder with key locking: code geometry,
// key FSM state encodings and a reference encoder for the matching transmitter.
package secded_lock_pkg;

    localparam logic [1:0] KEY_LOCKED   = 2'd0;
    localparam logic [1:0] KEY_LOAD     = 2'd1;
    localparam logic [1:0] KEY_UNLOCKED = 2'd2;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_CHK_W  = 8;

    function automatic int chk_w(input int data_w);
        return $clog2(data_w) + 2;
    endfunction

    // Codeword position of data bit i: the i-th non-power-of-two position >= 3.
    function automatic int data_pos(input int i);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 3; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == i && pos == 0) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    // Hamming check bits in [cw-2:0], overall parity (data + check) in [cw-1].
    function automatic logic [MAX_CHK_W-1:0] secded_encode(input logic [MAX_DATA_W-1:0] data,
                                                           input int data_w);
        logic [MAX_CHK_W-1:0] chk;
        logic [6:0]           syn;
        logic                 par;
        int                   cw;
        int                   pos;
        syn = '0;
        par = 1'b0;
        cw  = chk_w(data_w);
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < data_w && data[i]) begin
                pos = data_pos(i);
                syn = syn ^ pos[6:0];
                par = ~par;
            end
        end
        chk = '0;
        for (int b = 0; b < MAX_CHK_W - 1; b++) begin
            if (b < cw - 1) begin
                chk[b] = syn[b];
                par    = par ^ syn[b];
            end
        end
        chk[cw-1] = par;
        return chk;
    endfunction

endpackage

// File: rtl/secded_lock_pipe_if.sv
// Upstream/downstream word bus of the decoder. Both sides use valid/ready:
// a word moves on a rising edge where valid and ready are both high; valid must not depend on ready.
interface secded_lock_pipe_if
    import secded_lock_pkg::*;
#(
    parameter int DATA_W = 32
);
    localparam int CHK_W = chk_w(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CHK_W-1:0]  in_chk;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_corr;
    logic              out_uncorr;

    modport master (
        output in_valid, in_data, in_chk, out_ready,
        input  in_ready, out_valid, out_data, out_corr, out_uncorr
    );

    modport slave (
        input  in_valid, in_data, in_chk, out_ready,
        output in_ready, out_valid, out_data, out_corr, out_uncorr
    );
endinterface

// File: rtl/secded_lock_pipe_syndrome.sv
// Combinational syndrome and overall parity of a received SEC-DED codeword.
module secded_syndrome
    import secded_lock_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHK_W  = chk_w(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [CHK_W-1:0]  chk,
    output logic [CHK_W-2:0]  syn,
    output logic              par
);
    logic [CHK_W-2:0] pos_tab [DATA_W];

    for (genvar g = 0; g < DATA_W; g++) begin : g_pos
        assign pos_tab[g] = (CHK_W-1)'(data_pos(g));
    end

    always_comb begin
        syn = chk[CHK_W-2:0];
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) syn = syn ^ pos_tab[i];
        end
        par = ^{data, chk};
    end
endmodule

// File: rtl/secded_lock_pipe.sv
// Two-stage SEC-DED decoder/corrector whose output is XOR-masked until the
// correct key has been shifted in through the serial key port.
module secded_lock_pipe
    import secded_lock_pkg::*;
#(
    parameter int              DATA_W     = 32,
    parameter int              KEY_W      = 27,
    parameter logic [KEY_W-1:0] KEY_GOLDEN = 27'h5A3C1E7
) (
    input  logic               clk,
    input  logic               rst,
    secded_lock_pipe_if.slave  bus,
    input  logic               key_start,
    input  logic               key_shift,
    input  logic               key_bit,
    output logic               locked,
    output logic [1:0]         key_state
);
    localparam int CHK_W = chk_w(DATA_W);
    localparam int CNT_W = $clog2(KEY_W + 1);

    // ---------------- key FSM ----------------
    logic [1:0]       state;
    logic [KEY_W-1:0] key_reg;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= KEY_LOCKED;
            key_reg <= '0;
            cnt     <= '0;
        end else if (key_start) begin
            state   <= KEY_LOAD;
            key_reg <= '0;
            cnt     <= '0;
        end else if (state == KEY_LOAD) begin
            if (cnt == CNT_W'(KEY_W)) begin
                state <= (key_reg == KEY_GOLDEN) ? KEY_UNLOCKED : KEY_LOCKED;
            end else if (key_shift) begin
                key_reg <= {key_bit, key_reg[KEY_W-1:1]};
                cnt     <= cnt + CNT_W'(1);
            end
        end
    end

    assign locked    = (state != KEY_UNLOCKED);
    assign key_state = state;

    // Key difference repeated across the word; zero only for the golden key.
    logic [KEY_W-1:0]  key_diff;
    logic [DATA_W-1:0] mask_rep;
    logic [DATA_W-1:0] mask;

    assign key_diff = key_reg ^ KEY_GOLDEN;
    for (genvar g = 0; g < DATA_W; g++) begin : g_mask
        assign mask_rep[g] = key_diff[g % KEY_W];
    end
    assign mask = (state == KEY_UNLOCKED) ? '0 : mask_rep;

    // ---------------- stage 1: syndrome ----------------
    logic [CHK_W-2:0]  syn;
    logic              par;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [CHK_W-2:0]  s1_syn;
    logic              s1_par;
    logic              s1_advance;

    secded_syndrome #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syn (
        .data (bus.in_data),
        .chk  (bus.in_chk),
        .syn  (syn),
        .par  (par)
    );

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_corr_q;
    logic              out_uncorr_q;

    assign s1_advance   = s1_valid && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = !s1_valid || s1_advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data <= bus.in_data;
                s1_syn  <= syn;
                s1_par  <= par;
            end
        end
    end

    // ---------------- stage 2: correction and mask ----------------
    // Only an odd-weight error flips a bit; syndromes naming a check bit or
    // lying beyond the codeword match no data position and leave data alone.
    logic [DATA_W-1:0] flip;
    for (genvar g = 0; g < DATA_W; g++) begin : g_flip
        assign flip[g] = s1_par && (s1_syn == (CHK_W-1)'(data_pos(g)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_data_q   <= s1_data ^ flip ^ mask;
                out_corr_q   <= s1_par;
                out_uncorr_q <= !s1_par && (|s1_syn);
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_corr   = out_corr_q;
    assign bus.out_uncorr = out_uncorr_q;
endmodule

// File: tb/tb_secded_lock_pipe.sv
// Directed bench for secded_lock_pipe: reset, locking mask, correction,
// detection, back-to-back flow control with stalls, reset flush and key restart.
module tb_secded_lock_pipe;
    import secded_lock_pkg::*;

    localparam int          DW   = 32;
    localparam logic [26:0] GOLD = 27'h5A3C1E7;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_start;
    logic       key_shift;
    logic       key_bit;
    logic       locked;
    logic [1:0] key_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];

    secded_lock_pipe_if #(.DATA_W(DW)) bus();

    secded_lock_pipe #(.DATA_W(DW), .KEY_W(27), .KEY_GOLDEN(GOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .key_start (key_start),
        .key_shift (key_shift),
        .key_bit   (key_bit),
        .locked    (locked),
        .key_state (key_state)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [31:0] d);
        logic [7:0] c;
        c = secded_encode({32'h0, d}, DW);
        return c[6:0];
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_chk    = '0;
        bus.out_ready = 1'b1;
        key_start     = 1'b0;
        key_shift     = 1'b0;
        key_bit       = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_key(input logic [26:0] k);
        key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        for (int i = 0; i < 27; i++) begin
            key_shift = 1'b1;
            key_bit   = k[i];
            @(negedge clk);
        end
        key_shift = 1'b0;
        @(negedge clk);
    endtask

    // One word in, wait (bounded) for it to come out; lat = cycles to out_valid.
    task automatic xfer(input logic [31:0] d, input logic [6:0] c,
                        output logic [31:0] od, output logic oc, output logic ou, output int lat);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_chk    = c;
        bus.out_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat++;
        end while (!bus.out_valid && lat < 10);
        od = bus.out_data;
        oc = bus.out_corr;
        ou = bus.out_uncorr;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
        n_cmp++; if ({bus.out_corr, bus.out_uncorr} !== 2'b00) begin n_bad++; $display("FAIL rst_flags: got %b%b want 00", bus.out_corr, bus.out_uncorr); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL rst_locked: got %b want 1", locked); end
        n_cmp++; if (key_state !== KEY_LOCKED) begin n_bad++; $display("FAIL rst_state: got %0d want %0d", key_state, KEY_LOCKED); end
    endtask

    task automatic test_locked_mask();
        logic [31:0] od;
        logic        oc, ou;
        int          lat;
        xfer(32'h0, enc(32'h0), od, oc, ou, lat);
        n_cmp++; if (od !== 32'h3DA3C1E7) begin n_bad++; $display("FAIL nokey_data: got %h want 3da3c1e7", od); end
        n_cmp++; if ({oc, ou} !== 2'b00) begin n_bad++; $display("FAIL nokey_flags: got %b%b want 00", oc, ou); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL nokey_latency: got %0d want 2", lat); end
        load_key(27'h5A3C1E6);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL wrongkey_locked: got %b want 1", locked); end
        n_cmp++; if (key_state !== KEY_LOCKED) begin n_bad++; $display("FAIL wrongkey_state: got %0d want %0d", key_state, KEY_LOCKED); end
        xfer(32'h0, enc(32'h0), od, oc, ou, lat);
        n_cmp++; if (od !== 32'h08000001) begin n_bad++; $display("FAIL wrongkey_data: got %h want 08000001", od); end
    endtask

    task automatic test_clean();
        logic [31:0] od;
        logic        oc, ou;
        int          lat;
        load_key(GOLD);
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL golden_locked: got %b want 0", locked); end
        n_cmp++; if (key_state !== KEY_UNLOCKED) begin n_bad++; $display("FAIL golden_state: got %0d want %0d", key_state, KEY_UNLOCKED); end
        xfer(32'hDEADBEEF, enc(32'hDEADBEEF), od, oc, ou, lat);
        n_cmp++; if (od !== 32'hDEADBEEF) begin n_bad++; $display("FAIL clean_data: got %h want deadbeef", od); end
        n_cmp++; if ({oc, ou} !== 2'b00) begin n_bad++; $display("FAIL clean_flags: got %b%b want 00", oc, ou); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL clean_latency: got %0d want 2", lat); end
    endtask

    task automatic test_single();
        logic [31:0] od;
        logic        oc, ou;
        int          lat;
        logic [6:0]  c;
        c = enc(32'h12345678);
        xfer(32'h12365678, c, od, oc, ou, lat);
        n_cmp++; if (od !== 32'h12345678) begin n_bad++; $display("FAIL sec_data17: got %h want 12345678", od); end
        n_cmp++; if ({oc, ou} !== 2'b10) begin n_bad++; $display("FAIL sec_flags17: got %b%b want 10", oc, ou); end
        xfer(32'h12345678, c ^ 7'b0000100, od, oc, ou, lat);
        n_cmp++; if (od !== 32'h12345678) begin n_bad++; $display("FAIL sec_chk2_data: got %h want 12345678", od); end
        n_cmp++; if ({oc, ou} !== 2'b10) begin n_bad++; $display("FAIL sec_chk2_flags: got %b%b want 10", oc, ou); end
        xfer(32'h12345678, c ^ 7'b1000000, od, oc, ou, lat);
        n_cmp++; if ({oc, ou, od} !== {2'b10, 32'h12345678}) begin n_bad++; $display("FAIL sec_par_bit: got %b%b %h want 10 12345678", oc, ou, od); end
    endtask

    task automatic test_double();
        logic [31:0] od;
        logic        oc, ou;
        int          lat;
        xfer(32'h92345679, enc(32'h12345678), od, oc, ou, lat);
        n_cmp++; if (od !== 32'h92345679) begin n_bad++; $display("FAIL ded_data: got %h want 92345679", od); end
        n_cmp++; if ({oc, ou} !== 2'b01) begin n_bad++; $display("FAIL ded_flags: got %b%b want 01", oc, ou); end
    endtask

    task automatic test_back_to_back();
        int          idx, got, cyc;
        logic        prev_stall;
        logic [31:0] held, d;
        logic [32:0] e;
        idx = 0; got = 0; cyc = 0; prev_stall = 1'b0; held = '0;
        while (got < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = cyc[0];
            if (idx < 8) begin
                d             = 32'h0F1E2D3C ^ (idx * 32'h11111111);
                bus.in_valid  = 1'b1;
                bus.in_chk    = enc(d);
                bus.in_data   = idx[0] ? (d ^ (32'h1 << (idx * 4))) : d;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                n_cmp++; if ({bus.out_valid, bus.out_data} !== {1'b1, held}) begin n_bad++; $display("FAIL b2b_stall_hold: got %b %h want 1 %h", bus.out_valid, bus.out_data, held); end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL b2b_extra_word: got %h want none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++; if ({bus.out_corr, bus.out_data} !== e) begin n_bad++; $display("FAIL b2b_word%0d: got %b %h want %b %h", got, bus.out_corr, bus.out_data, e[32], e[31:0]); end
                end
                got++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held       = bus.out_data;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({idx[0], 32'h0F1E2D3C ^ (idx * 32'h11111111)});
                idx++;
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL b2b_count: got %0d want 8", got); end
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_no_dup: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 32'h100 + i;
            bus.in_chk    = enc(32'h100 + i);
            bus.out_ready = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_inflight: got %b want 1", bus.out_valid); end
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_discard: got %b want 0", bus.out_valid); end
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL flush_locked: got %b want 1", locked); end
    endtask

    task automatic test_key_restart();
        logic [31:0] od;
        logic        oc, ou;
        int          lat;
        key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            key_shift = 1'b1; key_bit = GOLD[i];
            @(negedge clk);
        end
        key_start = 1'b1; key_shift = 1'b1; key_bit = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        n_cmp++; if (key_state !== KEY_LOAD) begin n_bad++; $display("FAIL restart_state: got %0d want %0d", key_state, KEY_LOAD); end
        for (int i = 0; i < 26; i++) begin
            key_shift = 1'b1; key_bit = GOLD[i];
            @(negedge clk);
        end
        key_shift = 1'b0;
        @(negedge clk);
        n_cmp++; if ({locked, key_state} !== {1'b1, KEY_LOAD}) begin n_bad++; $display("FAIL restart_26: got %b %0d want 1 %0d", locked, key_state, KEY_LOAD); end
        key_shift = 1'b1; key_bit = GOLD[26];
        @(negedge clk);
        key_shift = 1'b0;
        @(negedge clk);
        n_cmp++; if ({locked, key_state} !== {1'b0, KEY_UNLOCKED}) begin n_bad++; $display("FAIL restart_27: got %b %0d want 0 %0d", locked, key_state, KEY_UNLOCKED); end
        xfer(32'hCAFEF00D, enc(32'hCAFEF00D), od, oc, ou, lat);
        n_cmp++; if (od !== 32'hCAFEF00D) begin n_bad++; $display("FAIL restart_data: got %h want cafef00d", od); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_locked_mask();
        test_clean();
        test_single();
        test_double();
        test_back_to_back();
        test_reset_flush();
        test_key_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
